vga_scan_timing: RTL and testbench
==================================

// Module: vga_scan_timing
// PURPOSE
//  Free-running VGA raster timing generator: drives the 11-bit pixel coordinates x/y consumed by the
//  rectangle/sprite renderers, plus hsync, vsync, video_on and frame/line strobes.
//  Sits between the pixel-clock enable source and every renderer/colour mux feeding the VGA pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (H_TOTAL = sum = 800)
//  V_ACTIVE 480 visible lines;        V_FP 10;  V_SYNC 2;   V_BP 33   (V_TOTAL = sum = 525)
//  HS_POL 0 hsync active level;  VS_POL 0 vsync active level
//  PIPE_DEPTH 2 extra sync/enable delay stages, used only with VGA_PIPE_ALIGN_EN
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  pix_ce       in   1   pixel clock enable; counters advance only on clk edges with pix_ce=1
//  x            out  11  horizontal pixel coordinate, 0..H_TOTAL-1
//  y            out  11  vertical line coordinate, 0..V_TOTAL-1
//  video_on     out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  hsync        out  1   horizontal sync at HS_POL level during the sync window
//  vsync        out  1   vertical sync at VS_POL level during the sync window
//  line_start   out  1   one-clk pulse when h_cnt wraps to 0
//  frame_start  out  1   one-clk pulse when (h_cnt,v_cnt) wraps to (0,0)
// BEHAVIOUR
//  - One clock domain, clk; reset is synchronous and active-high on rst. All outputs are registered.
//  - Internal h_cnt/v_cnt (11 bits each). On pix_ce: h_cnt++; at H_TOTAL-1 h_cnt->0 and v_cnt++;
//    at (H_TOTAL-1,V_TOTAL-1) both wrap to 0. Without pix_ce the counters hold.
//  - Output stage is a one-clk register copy of the counter decode: x=h_cnt, y=v_cnt,
//    video_on=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE),
//    hsync=HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL,
//    vsync=VS_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//  - Latency: outputs reflect counter values 1 clk after the counters update; x, y, video_on and
//    the syncs are mutually aligned.
//  - line_start/frame_start: high for exactly one clk, in the output cycle that first shows
//    h_cnt=0 (and v_cnt=0 for frame_start) after a wrap. No strobe is issued for the reset state.
//  - x/y keep counting through blanking; consumers must gate with video_on.
//  - Reset (any time, including mid-line): counters=0; x=0, y=0, video_on=0, hsync=~HS_POL,
//    vsync=~VS_POL, strobes=0. On the first clk after rst falls the output stage loads the (0,0)
//    decode (video_on=1) regardless of pix_ce.
//  - pix_ce held high continuously: a full frame is exactly H_TOTAL*V_TOTAL clks.
//  - The design requires H_TOTAL and V_TOTAL <= 2048. Sync windows must not overlap the active region.
// CONFIGURATION
//  - VGA_PIPE_ALIGN_EN defined: hsync, vsync, video_on, line_start and frame_start pass through
//    PIPE_DEPTH extra registers, advanced every clk. These stages reset to the same values as above.
//    x/y are not delayed. This matches renderer plus colour-mux register latency.
//  - Not defined: no extra stages. All outputs align with x/y as described in BEHAVIOUR.
// STRUCTURE
//  - vga_timing_pkg: H_/V_ timing constants for 640x480@60, COORD_W=11, and the H_TOTAL/V_TOTAL
//    derivation shared with the renderers.
//  - Sub-module vga_axis_counter (instanced twice, H and V): wrap counter with advance/wrap flags,
//    active decode and sync-window decode.
// TESTING
//  - Reset mid-line (h_cnt=300): assert rst for 1 clk -> x=0,y=0,video_on=0,hsync=vsync=1;
//    next clk video_on=1, no frame_start.
//  - pix_ce tied 1, run 800 clks -> line_start pulses once. x goes 639->640 with video_on 1->0;
//    hsync=0 exactly for x=656..751 (96 clks).
//  - Full frame: run 420000 clks -> frame_start spacing 420000. vsync=0 exactly for y=490..491;
//    video_on never 1 for y>=480.
//  - pix_ce toggling 1/0 every clk -> x advances every 2 clks. Line period = 1600 clks.
//    pix_ce=0 for 50 clks -> all outputs frozen.
//  - Wrap corner (x=799,y=524) + pix_ce -> x=0,y=0, frame_start and line_start both high for one clk.
//  - With VGA_PIPE_ALIGN_EN, PIPE_DEPTH=2 -> hsync falls 2 clks after x reaches 656.
//    Without the macro -> hsync falls in the same cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate width and the per-axis total derivation.
package vga_timing_pkg;

  localparam int unsigned COORD_W    = 11;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned H_FP       = 16;
  localparam int unsigned H_SYNC     = 96;
  localparam int unsigned H_BP       = 48;

  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned V_FP       = 10;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BP       = 33;

  localparam logic        HS_POL     = 1'b0;
  localparam logic        VS_POL     = 1'b0;
  localparam int unsigned PIPE_DEPTH = 2;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Control bundle that travels through the output stage (and optional alignment pipe).
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } scan_ctl_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with advance/wrap flags, active-region and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = 640,
  parameter int unsigned FP       = 16,
  parameter int unsigned SYNC     = 96,
  parameter int unsigned BP       = 48,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  output logic [COORD_W-1:0] cnt,
  output logic               last,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam logic [COORD_W-1:0] LAST_V     = COORD_W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [COORD_W-1:0] ACTIVE_V   = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    last   = (cnt == LAST_V);
    wrap   = adv && last;
    active = (cnt < ACTIVE_V);
    sync   = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

endmodule

// File: rtl/vga_scan_timing.sv
// Free-running VGA raster timing generator (registered x/y, syncs, video_on, line/frame strobes).
// Optional VGA_PIPE_ALIGN_EN delays the control outputs by PIPE_DEPTH clocks; x/y stay undelayed.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter logic        HS_POL     = vga_timing_pkg::HS_POL,
  parameter logic        VS_POL     = vga_timing_pkg::VS_POL,
  parameter int unsigned PIPE_DEPTH = vga_timing_pkg::PIPE_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam scan_ctl_t CTL_RST = '{video_on: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL,
                                    line_start: 1'b0, frame_start: 1'b0};

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_last, h_wrap, h_act, h_sync;
  logic               v_last, v_wrap, v_act, v_sync;
  logic               line_pend, frame_pend;
  scan_ctl_t          ctl_q, ctl_out;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(HS_POL)
  ) u_h (
    .clk(clk), .rst(rst), .adv(pix_ce),
    .cnt(h_cnt), .last(h_last), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(VS_POL)
  ) u_v (
    .clk(clk), .rst(rst), .adv(h_wrap),
    .cnt(v_cnt), .last(v_last), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );

  // A wrap on this edge means the next output load is the first to show the new line/frame;
  // remembering the wrap (rather than decoding cnt==0) keeps strobes single-clk when pix_ce stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_pend  <= 1'b0;
      frame_pend <= 1'b0;
      x          <= '0;
      y          <= '0;
      ctl_q      <= CTL_RST;
    end else begin
      line_pend  <= h_wrap;
      frame_pend <= h_wrap && v_wrap;
      x          <= h_cnt;
      y          <= v_cnt;
      ctl_q      <= '{video_on: h_act && v_act, hsync: h_sync, vsync: v_sync,
                      line_start: line_pend, frame_start: frame_pend};
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  scan_ctl_t ctl_pipe [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) ctl_pipe[i] <= CTL_RST;
    end else begin
      ctl_pipe[0] <= ctl_q;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign ctl_out = ctl_pipe[PIPE_DEPTH-1];
`else
  assign ctl_out = ctl_q;
`endif

  assign video_on    = ctl_out.video_on;
  assign hsync       = ctl_out.hsync;
  assign vsync       = ctl_out.vsync;
  assign line_start  = ctl_out.line_start;
  assign frame_start = ctl_out.frame_start;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: default 640x480 instance plus a shrunken-geometry instance for frame wraps.
module tb_vga_scan_timing;

  typedef struct packed {
    logic vo;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } m_t;

`ifdef VGA_PIPE_ALIGN_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  localparam m_t M_RST = '{vo: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};

  // geometry per instance: h active/fp/sync/bp, v active/fp/sync/bp
  int geo [2][8] = '{'{640, 16, 96, 48, 480, 10, 2, 33},
                     '{16, 2, 4, 3, 6, 2, 2, 3}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [10:0] dut_x [2];
  logic [10:0] dut_y [2];
  logic        dut_vo [2];
  logic        dut_hs [2];
  logic        dut_vs [2];
  logic        dut_ls [2];
  logic        dut_fs [2];

  always #5 clk = ~clk;

  vga_scan_timing dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(dut_x[0]), .y(dut_y[0]), .video_on(dut_vo[0]), .hsync(dut_hs[0]), .vsync(dut_vs[0]),
    .line_start(dut_ls[0]), .frame_start(dut_fs[0])
  );

  vga_scan_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(dut_x[1]), .y(dut_y[1]), .video_on(dut_vo[1]), .hsync(dut_hs[1]), .vsync(dut_vs[1]),
    .line_start(dut_ls[1]), .frame_start(dut_fs[1])
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  longint      n = 0;        // total pixel advances since last reset
  longint      prev_shown = 0;
  int          ex_x [2];
  int          ex_y [2];
  m_t          stg [2][D+1];

  task automatic chk(input string tag, input int g, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] cyc=%0d got=%0d exp=%0d", tag, g, cyc, obs, exp);
    end
  endtask

  // Reference: the raster position is simply the advance count modulo the frame size.
  task automatic model(input logic r, input logic c);
    longint shown, pos;
    int     ht, vt, h, v;
    bit     changed;
    m_t     m;
    if (r) begin
      n = 0;
      prev_shown = 0;
      for (int g = 0; g < 2; g++) begin
        ex_x[g] = 0;
        ex_y[g] = 0;
        for (int k = 0; k <= D; k++) stg[g][k] = M_RST;
      end
    end else begin
      shown = n;
      changed = (shown != prev_shown);
      prev_shown = shown;
      for (int g = 0; g < 2; g++) begin
        ht = geo[g][0] + geo[g][1] + geo[g][2] + geo[g][3];
        vt = geo[g][4] + geo[g][5] + geo[g][6] + geo[g][7];
        pos = shown % longint'(ht * vt);
        h = int'(pos % ht);
        v = int'(pos / ht);
        ex_x[g] = h;
        ex_y[g] = v;
        m.vo = (h < geo[g][0]) && (v < geo[g][4]);
        m.hs = !((h >= geo[g][0] + geo[g][1]) && (h < geo[g][0] + geo[g][1] + geo[g][2]));
        m.vs = !((v >= geo[g][4] + geo[g][5]) && (v < geo[g][4] + geo[g][5] + geo[g][6]));
        m.ls = changed && (h == 0);
        m.fs = changed && (h == 0) && (v == 0);
        for (int k = D; k > 0; k--) stg[g][k] = stg[g][k-1];
        stg[g][0] = m;
      end
      if (c) n++;
    end
  endtask

  task automatic step(input logic r, input logic c);
    rst = r;
    pix_ce = c;
    @(posedge clk);
    model(r, c);
    #1;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      chk("x", g, dut_x[g], ex_x[g]);
      chk("y", g, dut_y[g], ex_y[g]);
      chk("video_on", g, dut_vo[g], stg[g][D].vo);
      chk("hsync", g, dut_hs[g], stg[g][D].hs);
      chk("vsync", g, dut_vs[g], stg[g][D].vs);
      chk("line_start", g, dut_ls[g], stg[g][D].ls);
      chk("frame_start", g, dut_fs[g], stg[g][D].fs);
    end
  endtask

  initial begin
    int last_ev;
    int hs_low;
    logic [10:0] fx, fy;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_x", 0, dut_x[0], 0);
    chk("rst_hsync", 0, dut_hs[0], 1);

    // run to mid-line, then a single-cycle reset
    for (int i = 0; i < 301; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("midrst_vo", 0, dut_vo[0], 0);
    step(1'b0, 1'b1);
    chk("post_rst_fs", 0, dut_fs[0], 0);

    // continuous pixel enable: measure hsync low width on the full-size instance
    hs_low = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b0, 1'b1);
      if (dut_hs[0] == 1'b0) hs_low++;
    end
    chk("hs_low_2lines", 0, hs_low, 2 * 96);

    // half-rate enable: line period doubles
    last_ev = -1;
    for (int i = 0; i < 3400; i++) begin
      step(1'b0, (i % 2) == 0);
      if (dut_ls[0]) begin
        if (last_ev >= 0) chk("line_gap_half", 0, cyc - last_ev, 1600);
        last_ev = cyc;
      end
    end

    // enable held low: outputs frozen
    step(1'b0, 1'b0);
    fx = dut_x[0];
    fy = dut_y[0];
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    chk("frozen_x", 0, dut_x[0], fx);
    chk("frozen_y", 0, dut_y[0], fy);

    // random enable with rare resets
    for (int i = 0; i < 12000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);

    // continuous enable: frame period of the small geometry
    last_ev = -1;
    for (int i = 0; i < 1400; i++) begin
      step(1'b0, 1'b1);
      if (dut_fs[1]) begin
        chk("fs_has_ls", 1, dut_ls[1], 1);
        if (last_ev >= 0) chk("frame_gap", 1, cyc - last_ev, 25 * 13);
        last_ev = cyc;
      end
    end
    chk("frame_seen", 1, last_ev >= 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
